config_bank_writer: RTL and testbench
=====================================

// Module: config_bank_writer
// PURPOSE
//  Initiator side of the tile configuration-bank interface (enable / address / data_in).
//  Accepts a serial configuration bitstream over a valid/ready handshake.
//  Writes one bit per address, in ascending address order, into a tile-level memory bank.
//  Drives the enable/address/data_in inputs of a grid tile (decoder + per-bit config cells) under prog_clk.
// PARAMETERS
//  ADDR_WIDTH  4   width of address bus; address[0] is MSB
//  NUM_WORDS   16  bits written per frame; legal range 1..2**ADDR_WIDTH
// PORTS
//  prog_clk    input   1             configuration clock; all logic on rising edge
//  pReset      input   1             synchronous, active-high reset
//  start       input   1             begin a frame; sampled only in IDLE
//  abort       input   1             cancel frame in progress; sampled in any non-IDLE state
//  bs_valid    input   1             bitstream bit available
//  bs_data     input   1             bitstream bit value
//  bs_ready    output  1             writer can accept a bit (combinational from state == WAIT)
//  enable      output  1             registered one-cycle write strobe to tile decoder
//  address     output  [0:ADDR_WIDTH-1]  registered bank address, binary, address[0] MSB
//  data_in     output  1             registered bit to write
//  busy        output  1             high in WAIT/STROBE/HOLD
//  done        output  1             one-cycle pulse when all NUM_WORDS bits are written
//  wr_count    output  [0:ADDR_WIDTH]  number of strobes issued in current/last frame
// BEHAVIOUR
//  Reset: state IDLE; enable=0, address=0, data_in=0, done=0, wr_count=0. bs_ready=0, busy=0.
//  States: IDLE, WAIT, STROBE, HOLD, DONE.
//  IDLE:
//   - start=1 -> WAIT next cycle; address<=0, wr_count<=0.
//   - start=0 -> stay IDLE.
//  WAIT:
//   - bs_ready=1.
//   - Handshake (bs_valid&bs_ready) at edge W -> STROBE; data_in<=bs_data, enable<=1 (visible cycle W+1).
//  STROBE:
//   - enable=1 for exactly one cycle; address/data_in stable.
//   - Next state HOLD; enable<=0; wr_count<=wr_count+1.
//  HOLD:
//   - enable=0; address/data_in still held, giving tile hold time.
//   - If address==NUM_WORDS-1 -> DONE, address unchanged.
//   - Else -> WAIT; address<=address+1.
//  DONE:
//   - done=1 for one cycle; busy=0.
//   - Next state IDLE; address/data_in/wr_count retained until next start.
//  Timing:
//   - Minimum 3 cycles per bit (WAIT->STROBE->HOLD); no back-to-back strobes.
//   - bs_valid low in WAIT: stall indefinitely, outputs stable.
//  start outside IDLE: ignored. start in DONE: ignored (needs IDLE).
//  abort (non-IDLE):
//   - IDLE next cycle; enable<=0; done not pulsed; wr_count keeps partial count.
//   - In STROBE: the current strobe still completes (enable is registered).
//   - abort and handshake in the same WAIT cycle: abort wins and the bit is not consumed (bs_ready forced 0).
//  pReset has priority over all inputs; mid-frame reset returns to reset values next edge.
//  Address never exceeds NUM_WORDS-1; no wrap.
//  wr_count width ADDR_WIDTH+1 so it can hold 2**ADDR_WIDTH.
// TESTING
//  1. Full frame, bs_valid tied 1, bits 1010_1100_0011_0101 -> 16 strobes.
//     Strobe k: address=k, data_in=bit k, 3 cycles apart; done once after last HOLD; wr_count=16.
//  2. Stall: bs_valid low 10 cycles in WAIT at address 5 -> bs_ready stays 1, enable stays 0, address stays 5.
//     Resume -> strobe at address 5.
//  3. Abort in WAIT after 7 strobes -> IDLE next cycle, no done, wr_count=7, bit pending on bs_data not consumed.
//     New start -> address restarts at 0.
//  4. Abort asserted during STROBE at address 3 -> that strobe completes (enable high 1 cycle), no further strobes.
//  5. pReset during HOLD at address 9 -> all outputs at reset values next cycle; start ignored while busy.
//  6. NUM_WORDS=1 -> single strobe at address 0, then done; start in same cycle as done ignored.

Source files
------------

// File: rtl/config_bank_writer.sv
// -----------------------------------------------------------------------------
// config_bank_writer
//
// Initiator side of the tile configuration-bank interface. A frame is opened
// with start, then NUM_WORDS bitstream bits are accepted one at a time over a
// valid/ready handshake. Each bit is written to the tile with a one-cycle
// enable strobe at an ascending address (0, 1, 2, ...). Every bit takes at
// least three cycles: WAIT (handshake), STROBE (enable high), HOLD (address
// and data held with enable low, giving the tile hold time).
//
// Ports
//   prog_clk  in   configuration clock, all logic on the rising edge
//   pReset    in   synchronous active-high reset, highest priority
//   start     in   open a frame (only looked at in IDLE)
//   abort     in   cancel the frame in progress (any non-IDLE state)
//   bs_valid  in   bitstream bit available
//   bs_data   in   bitstream bit value
//   bs_ready  out  writer accepts a bit this cycle (WAIT and no abort)
//   enable    out  registered one-cycle write strobe to the tile decoder
//   address   out  registered bank address, binary, address[0] is the MSB
//   data_in   out  registered bit being written
//   busy      out  high while in WAIT, STROBE or HOLD
//   done      out  one-cycle pulse once all NUM_WORDS bits are written
//   wr_count  out  strobes issued in the current or most recent frame
// -----------------------------------------------------------------------------
module config_bank_writer #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WORDS  = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  bs_valid,
    input  logic                  bs_data,
    output logic                  bs_ready,
    output logic                  enable,
    output logic [0:ADDR_WIDTH-1] address,
    output logic                  data_in,
    output logic                  busy,
    output logic                  done,
    output logic [0:ADDR_WIDTH]   wr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_e;

    localparam logic [0:ADDR_WIDTH-1] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [0:ADDR_WIDTH-1] ADDR_INC  = ADDR_WIDTH'(1);
    localparam logic [0:ADDR_WIDTH]   CNT_INC   = (ADDR_WIDTH + 1)'(1);

    state_e                  state_q,    state_d;
    logic                    enable_q,   enable_d;
    logic [0:ADDR_WIDTH-1]   address_q,  address_d;
    logic                    data_in_q,  data_in_d;
    logic                    done_q,     done_d;
    logic [0:ADDR_WIDTH]     wr_count_q, wr_count_d;

    logic                    handshake;

    // An abort in WAIT drops ready so the bit on bs_data stays with the source.
    assign bs_ready  = (state_q == S_WAIT) && !abort;
    assign handshake = bs_valid && bs_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the value.
        state_d    = state_q;
        enable_d   = 1'b0;
        address_d  = address_q;
        data_in_d  = data_in_q;
        done_d     = 1'b0;
        wr_count_d = wr_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WAIT;
                    address_d  = '0;
                    wr_count_d = '0;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (handshake) begin
                    state_d   = S_STROBE;
                    data_in_d = bs_data;
                    enable_d  = 1'b1;
                end
            end

            S_STROBE: begin
                // enable is already on the wire this cycle, so even an abort
                // here lets the strobe finish and it is counted.
                wr_count_d = wr_count_q + CNT_INC;
                state_d    = abort ? S_IDLE : S_HOLD;
            end

            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (address_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_WAIT;
                    address_d = address_q + ADDR_INC;
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here; a new frame needs IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (pReset) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            address_q  <= '0;
            data_in_q  <= 1'b0;
            done_q     <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            address_q  <= address_d;
            data_in_q  <= data_in_d;
            done_q     <= done_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign enable   = enable_q;
    assign address  = address_q;
    assign data_in  = data_in_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;
    assign busy     = (state_q == S_WAIT) || (state_q == S_STROBE) || (state_q == S_HOLD);

endmodule

// File: tb/tb_config_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_config_bank_writer
//
// Bench for config_bank_writer. dut (16 words) carries the table vectors, the
// directed frame sequences and a randomized run against a timeline model;
// dut1 (1 word) covers the single-word frame.
// -----------------------------------------------------------------------------
module tb_config_bank_writer;

    localparam int AW  = 4;
    localparam int NW  = 16;
    localparam int BIG = 1 << 30;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start, abort, bs_valid, bs_data;
    logic          bs_ready, enable, data_in, busy, done;
    logic [0:AW-1] address;
    logic [0:AW]   wr_count;

    logic          u_start, u_abort, u_valid, u_data;
    logic          u_ready, u_enable, u_data_in, u_busy, u_done;
    logic [0:AW-1] u_address;
    logic [0:AW]   u_wr_count;

    config_bank_writer #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (start),
        .abort    (abort),
        .bs_valid (bs_valid),
        .bs_data  (bs_data),
        .bs_ready (bs_ready),
        .enable   (enable),
        .address  (address),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
    );

    config_bank_writer #(.ADDR_WIDTH(AW), .NUM_WORDS(1)) dut1 (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (u_start),
        .abort    (u_abort),
        .bs_valid (u_valid),
        .bs_data  (u_data),
        .bs_ready (u_ready),
        .enable   (u_enable),
        .address  (u_address),
        .data_in  (u_data_in),
        .busy     (u_busy),
        .done     (u_done),
        .wr_count (u_wr_count)
    );

    always #5 prog_clk = ~prog_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Move to 1 time unit after the next rising edge; inputs are driven here
    // and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset();
        pReset   = 1'b1;
        start    = 1'b0; abort   = 1'b0; bs_valid = 1'b0; bs_data = 1'b0;
        u_start  = 1'b0; u_abort = 1'b0; u_valid  = 1'b0; u_data  = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        pReset = 1'b0;
    endtask

    // in_bits = {start, abort, bs_valid, bs_data}
    // exp_bits = {bs_ready, enable, address[0:3], data_in, busy, done, wr_count[0:4]}
    typedef struct {
        logic [3:0]  in_bits;
        logic [13:0] exp_bits;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ins, input logic [1:0] rdy_en,
                                input logic [3:0] a, input logic [2:0] din_busy_done,
                                input logic [4:0] wc);
        vec_t v;
        v.in_bits  = ins;
        v.exp_bits = {rdy_en, a, din_busy_done, wc};
        return v;
    endfunction

    vec_t        vecs [11];
    logic [15:0] pat;
    int          idx, n_str, n_done, last_str, done_cyc, stall, hit, prev9;

    // Timeline model for the randomized run.
    int   m_active, m_ready_at, m_strobe_at, m_done_at, m_nacc, m_wc, m_saddr, n_rdone;
    logic m_sdata;
    logic exp_en, exp_done, exp_rdy, exp_busy;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pat = 16'b1010_1100_0011_0101;

        // ---------------- table vectors ----------------
        vecs[0]  = mk(4'b1000, 2'b00, 4'd0, 3'b000, 5'd0); // reset state, start
        vecs[1]  = mk(4'b0011, 2'b10, 4'd0, 3'b010, 5'd0); // WAIT, handshake bit 1
        vecs[2]  = mk(4'b0000, 2'b01, 4'd0, 3'b110, 5'd0); // STROBE
        vecs[3]  = mk(4'b0000, 2'b00, 4'd0, 3'b110, 5'd1); // HOLD
        vecs[4]  = mk(4'b0000, 2'b10, 4'd1, 3'b110, 5'd1); // WAIT addr 1, stall
        vecs[5]  = mk(4'b0110, 2'b00, 4'd1, 3'b110, 5'd1); // abort beats handshake
        vecs[6]  = mk(4'b0010, 2'b00, 4'd1, 3'b100, 5'd1); // IDLE, valid ignored
        vecs[7]  = mk(4'b1010, 2'b00, 4'd1, 3'b100, 5'd1); // restart
        vecs[8]  = mk(4'b0010, 2'b10, 4'd0, 3'b110, 5'd0); // WAIT addr 0, handshake bit 0
        vecs[9]  = mk(4'b0100, 2'b01, 4'd0, 3'b010, 5'd0); // abort during STROBE
        vecs[10] = mk(4'b0000, 2'b00, 4'd0, 3'b000, 5'd1); // IDLE, strobe counted

        do_reset();
        for (int i = 0; i < 11; i++) begin
            {start, abort, bs_valid, bs_data} = vecs[i].in_bits;
            #1;
            check($sformatf("vec%0d", i),
                  32'({bs_ready, enable, address, data_in, busy, done, wr_count}),
                  32'(vecs[i].exp_bits));
            tick();
        end

        // ---------------- full frame, bs_valid tied high ----------------
        do_reset();
        idx = 0; n_str = 0; n_done = 0; last_str = -1; done_cyc = -1;
        for (int c = 0; c < 80; c++) begin
            start    = (c == 0);
            abort    = 1'b0;
            bs_valid = 1'b1;
            bs_data  = (idx < NW) ? pat[15 - idx] : 1'b0;
            #1;
            if (enable) begin
                check($sformatf("frame_addr%0d", n_str), 32'(address), 32'(n_str));
                if (n_str < NW)
                    check($sformatf("frame_data%0d", n_str), 32'(data_in), 32'(pat[15 - n_str]));
                if (n_str > 0)
                    check($sformatf("frame_gap%0d", n_str), 32'(c - last_str), 32'd3);
                last_str = c;
                n_str++;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (bs_valid && bs_ready) idx++;
            tick();
        end
        check("frame_strobes", 32'(n_str), 32'd16);
        check("frame_done_count", 32'(n_done), 32'd1);
        check("frame_done_timing", 32'(done_cyc), 32'(last_str + 2));
        check("frame_wr_count", 32'(wr_count), 32'd16);
        check("frame_bits_taken", 32'(idx), 32'd16);

        // ---------------- stall at address 5 ----------------
        do_reset();
        idx = 0; stall = 0; hit = 0;
        for (int c = 0; c < 80; c++) begin
            start    = (c == 0);
            bs_valid = 1'b1;
            if (bs_ready && address == 4'd5 && stall < 10) begin
                bs_valid = 1'b0;
                stall++;
            end
            bs_data = (idx < NW) ? pat[15 - idx] : 1'b0;
            #1;
            if (!bs_valid) begin
                check("stall_ready", 32'(bs_ready), 32'd1);
                check("stall_enable", 32'(enable), 32'd0);
                check("stall_addr", 32'(address), 32'd5);
            end
            if (enable && address == 4'd5) begin
                check("stall_resume_data", 32'(data_in), 32'(pat[10]));
                check("stall_length", 32'(stall), 32'd10);
                hit = 1;
            end
            if (bs_valid && bs_ready) idx++;
            tick();
            if (hit != 0) break;
        end
        check("stall_resumed", 32'(hit), 32'd1);

        // ---------------- abort in WAIT after 7 strobes ----------------
        do_reset();
        idx = 0; hit = 0;
        for (int c = 0; c < 80; c++) begin
            start    = (c == 0);
            abort    = 1'b0;
            bs_valid = 1'b1;
            bs_data  = (idx < NW) ? pat[15 - idx] : 1'b0;
            if (bs_ready && wr_count == 5'd7) begin
                abort   = 1'b1;
                bs_data = 1'b1;
            end
            #1;
            if (abort) begin
                check("abort_wait_ready", 32'(bs_ready), 32'd0);
                check("abort_wait_addr", 32'(address), 32'd7);
                hit = 1;
            end
            if (bs_valid && bs_ready) idx++;
            tick();
            if (hit != 0) break;
        end
        check("abort_wait_reached", 32'(hit), 32'd1);
        abort = 1'b0; start = 1'b0; bs_valid = 1'b1;
        #1;
        check("abort_wait_idle", 32'({busy, done, enable}), 32'd0);
        check("abort_wait_count", 32'(wr_count), 32'd7);
        tick();
        #1;
        check("abort_wait_no_strobe", 32'({enable, busy, done}), 32'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("abort_restart_addr", 32'(address), 32'd0);
        check("abort_restart_count", 32'(wr_count), 32'd0);
        check("abort_restart_ready", 32'(bs_ready), 32'd1);
        tick();

        // ---------------- abort during STROBE at address 3 ----------------
        do_reset();
        hit = 0;
        for (int c = 0; c < 80; c++) begin
            start    = (c == 0);
            abort    = 1'b0;
            bs_valid = 1'b1;
            bs_data  = 1'b0;
            if (enable && address == 4'd3) abort = 1'b1;
            #1;
            if (abort) begin
                check("abort_strobe_enable", 32'(enable), 32'd1);
                hit = 1;
            end
            tick();
            if (hit != 0) break;
        end
        check("abort_strobe_reached", 32'(hit), 32'd1);
        abort = 1'b0;
        n_str = 0;
        #1;
        check("abort_strobe_idle", 32'({busy, done}), 32'd0);
        for (int c = 0; c < 12; c++) begin
            if (enable) n_str++;
            tick();
            #1;
        end
        check("abort_strobe_no_more", 32'(n_str), 32'd0);
        check("abort_strobe_count", 32'(wr_count), 32'd4);
        tick();

        // ---------------- reset during HOLD at address 9, start held high ----------------
        do_reset();
        hit = 0; n_str = 0; prev9 = 0;
        for (int c = 0; c < 80; c++) begin
            start    = 1'b1;
            bs_valid = 1'b1;
            bs_data  = 1'b1;
            if (prev9 != 0) begin
                pReset = 1'b1;
                hit    = 1;
            end
            #1;
            if (enable) begin
                check($sformatf("busy_start_addr%0d", n_str), 32'(address), 32'(n_str));
                n_str++;
            end
            prev9 = (enable && address == 4'd9) ? 1 : 0;
            tick();
            if (hit != 0) break;
        end
        check("reset_hold_reached", 32'(hit), 32'd1);
        pReset = 1'b0; start = 1'b0; bs_valid = 1'b0;
        #1;
        check("reset_hold_outputs",
              32'({bs_ready, enable, address, data_in, busy, done, wr_count}), 32'd0);
        tick();

        // ---------------- single-word frame on dut1 ----------------
        do_reset();
        u_start = 1'b1; u_valid = 1'b1; u_data = 1'b1;
        #1;
        check("one_idle", 32'({u_ready, u_enable, u_busy, u_done}), 32'd0);
        tick();
        u_start = 1'b0;
        #1;
        check("one_wait", 32'({u_ready, u_busy}), 32'b11);
        tick();
        #1;
        check("one_strobe", 32'({u_enable, u_address, u_data_in}), 32'b1_0000_1);
        tick();
        #1;
        check("one_hold", 32'({u_enable, u_busy, u_done}), 32'b010);
        tick();
        u_start = 1'b1;
        #1;
        check("one_done", 32'({u_done, u_busy, u_address}), 32'b10_0000);
        check("one_count", 32'(u_wr_count), 32'd1);
        tick();
        u_start = 1'b0;
        #1;
        check("one_after_done", 32'({u_busy, u_done, u_ready}), 32'd0);
        tick();
        #1;
        check("one_start_ignored", 32'({u_busy, u_ready, u_enable}), 32'd0);
        tick();

        // ---------------- randomized run against a timeline model ----------------
        // A handshake at the edge ending cycle c puts the strobe in c+1; the
        // next bit is offered from c+3, or for the last bit done shows in c+3.
        do_reset();
        m_active = 0; m_ready_at = BIG; m_strobe_at = -1; m_done_at = -1;
        m_nacc = 0; m_wc = 0; m_saddr = 0; m_sdata = 1'b0; n_rdone = 0;
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 149) == 0);
            bs_valid = ($urandom_range(0, 9) < 6);
            bs_data  = 1'($urandom_range(0, 1));
            #1;
            exp_en   = (c == m_strobe_at);
            exp_done = (c == m_done_at);
            exp_rdy  = (m_active != 0) && (c >= m_ready_at) && !abort;
            exp_busy = (m_active != 0) && !exp_done;
            check("rnd_ctrl", 32'({bs_ready, enable, busy, done, wr_count}),
                  32'({exp_rdy, exp_en, exp_busy, exp_done, 5'(m_wc)}));
            if (exp_en) begin
                check("rnd_strobe_addr", 32'(address), 32'(m_saddr));
                check("rnd_strobe_data", 32'(data_in), 32'(m_sdata));
            end
            if (exp_rdy)
                check("rnd_wait_addr", 32'(address), 32'(m_nacc));
            if (exp_done) n_rdone++;

            if (exp_en) m_wc++;
            if (m_active == 0) begin
                if (start) begin
                    m_active   = 1;
                    m_ready_at = c + 1;
                    m_nacc     = 0;
                    m_wc       = 0;
                end
            end else if (abort) begin
                m_active   = 0;
                m_ready_at = BIG;
                m_done_at  = -1;
            end else begin
                if (exp_rdy && bs_valid) begin
                    m_strobe_at = c + 1;
                    m_saddr     = m_nacc;
                    m_sdata     = bs_data;
                    m_nacc++;
                    if (m_nacc == NW) begin
                        m_done_at  = c + 3;
                        m_ready_at = BIG;
                    end else begin
                        m_ready_at = c + 3;
                    end
                end
                if (exp_done) m_active = 0;
            end
            tick();
        end
        check("rnd_frames_completed", 32'(n_rdone > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
